// File: rtl/vga_draw_pkg.sv
// Shared types and geometry constants for the VGA draw arbiter.
package vga_draw_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // 160x120 mode
    localparam int X_WIDTH_160 = 8;
    localparam int Y_WIDTH_120 = 7;
    localparam int X_MAX_160   = 159;
    localparam int Y_MAX_120   = 119;

    // 320x240 mode
    localparam int X_WIDTH_320 = 9;
    localparam int Y_WIDTH_240 = 8;
    localparam int X_MAX_320   = 319;
    localparam int Y_MAX_240   = 239;

    localparam int COLOUR_WIDTH_DEF = 3;
    localparam int CLEAR_COLOUR_DEF = 0;

    // Number of plot cycles in one full-frame clear pass.
    function automatic int clear_len(input int x_max, input int y_max);
        return (x_max + 1) * (y_max + 1);
    endfunction

    localparam int CLEAR_LEN_160 = clear_len(X_MAX_160, Y_MAX_120);

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Draw-request / adapter-write bundle between the drawing engines and the arbiter.
interface vga_draw_arbiter_if
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int X_WIDTH      = X_WIDTH_160,
    parameter int Y_WIDTH      = Y_WIDTH_120,
    parameter int COLOUR_WIDTH = COLOUR_WIDTH_DEF
);
    logic                              frame_start;
    logic                              clear_en;
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ*X_WIDTH-1:0]        req_x;
    logic [NUM_REQ*Y_WIDTH-1:0]        req_y;
    logic [NUM_REQ*COLOUR_WIDTH-1:0]   req_colour;
    logic [NUM_REQ-1:0]                grant;
    logic [X_WIDTH-1:0]                x;
    logic [Y_WIDTH-1:0]                y;
    logic [COLOUR_WIDTH-1:0]           colour;
    logic                              plot;
    logic                              busy_clear;
    logic                              clear_done;
    logic                              range_err;

    modport master (
        output frame_start, clear_en, req, req_x, req_y, req_colour,
        input  grant, x, y, colour, plot, busy_clear, clear_done, range_err
    );

    modport slave (
        input  frame_start, clear_en, req, req_x, req_y, req_colour,
        output grant, x, y, colour, plot, busy_clear, clear_done, range_err
    );
endinterface

// File: rtl/vga_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request after the pointer.
module vga_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx,
    output logic               valid
);
    int               sum;
    logic [PTR_W-1:0] idx;

    // Scan pointer+1 .. pointer (wrapping); the pointer's own slot is checked last.
    always_comb begin
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx] && !mask[idx]) begin
                valid    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin sharing of the VGA adapter write port, with a full-frame clear pass.
//
//   state | meaning
//   SERVE | arbitrate drawing requests, one registered write per grant
//   CLEAR | raster-order clear of the whole frame at CLEAR_COLOUR
module vga_draw_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int X_WIDTH      = X_WIDTH_160,
    parameter int Y_WIDTH      = Y_WIDTH_120,
    parameter int COLOUR_WIDTH = COLOUR_WIDTH_DEF,
    parameter int X_MAX        = X_MAX_160,
    parameter int Y_MAX        = Y_MAX_120,
    parameter int CLEAR_COLOUR = CLEAR_COLOUR_DEF
) (
    input  logic               clock,
    input  logic               reset,
    vga_draw_arbiter_if.slave  bus
);
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CLEAR_LEN = clear_len(X_MAX, Y_MAX);
    localparam int CNT_W     = $clog2(CLEAR_LEN + 1);

    localparam logic [X_WIDTH-1:0]      X_LAST   = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0]      Y_LAST   = Y_WIDTH'(Y_MAX);
    localparam logic [COLOUR_WIDTH-1:0] CLR_COL  = COLOUR_WIDTH'(CLEAR_COLOUR);
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(CLEAR_LEN - 1);
    localparam logic [PTR_W-1:0]        PTR_INIT = PTR_W'(NUM_REQ - 1);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [X_WIDTH-1:0]      x_q, x_d;
    logic [Y_WIDTH-1:0]      y_q, y_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    plot_q, plot_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0]      win;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_valid;

    logic [X_WIDTH-1:0]      rx [NUM_REQ];
    logic [Y_WIDTH-1:0]      ry [NUM_REQ];
    logic [COLOUR_WIDTH-1:0] rc [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rx[g] = bus.req_x[g*X_WIDTH +: X_WIDTH];
        assign ry[g] = bus.req_y[g*Y_WIDTH +: Y_WIDTH];
        assign rc[g] = bus.req_colour[g*COLOUR_WIDTH +: COLOUR_WIDTH];
    end

    // Masking with the current grant stops a still-held request winning twice in a row.
    vga_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req     (bus.req),
        .mask    (grant_q),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .valid   (win_valid)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= SERVE;
        else       state_q <= state_d;
    end

    // Next state and next registered outputs; clear pass is a down-counter to zero.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            SERVE: begin
                if (bus.frame_start && bus.clear_en) begin
                    state_d  = CLEAR;
                    x_d      = '0;
                    y_d      = '0;
                    colour_d = CLR_COL;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_LOAD;
                end else if (win_valid) begin
                    grant_d  = win;
                    ptr_d    = win_idx;
                    x_d      = rx[win_idx];
                    y_d      = ry[win_idx];
                    colour_d = rc[win_idx];
                    if (rx[win_idx] > X_LAST || ry[win_idx] > Y_LAST) err_d  = 1'b1;
                    else                                              plot_d = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = SERVE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    colour_d = CLR_COL;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = SERVE;
        endcase
    end

    // Registered outputs, pointer and clear counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q    <= PTR_INIT;
            grant_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy_clear = busy_q;
    assign bus.clear_done = done_q;
    assign bus.range_err  = err_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: arbitration, range errors, clear pass, reset mid-clear.
module tb_vga_draw_arbiter;
    import vga_draw_pkg::*;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_pass;

    vga_draw_arbiter_if #(.NUM_REQ(2), .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(3)) bus ();

    vga_draw_arbiter #(
        .NUM_REQ(2), .X_WIDTH(8), .Y_WIDTH(7), .COLOUR_WIDTH(3),
        .X_MAX(159), .Y_MAX(119), .CLEAR_COLOUR(0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_req(input logic [1:0] r,
                           input int x0, input int y0, input int c0,
                           input int x1, input int y1, input int c1);
        bus.req        = r;
        bus.req_x      = {8'(x1), 8'(x0)};
        bus.req_y      = {7'(y1), 7'(y0)};
        bus.req_colour = {3'(c1), 3'(c0)};
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, bus.grant, 0);
        check({tag, "_plot"}, bus.plot, 0);
        check({tag, "_busy"}, bus.busy_clear, 0);
        check({tag, "_done"}, bus.clear_done, 0);
        check({tag, "_err"}, bus.range_err, 0);
        check({tag, "_x"}, bus.x, 0);
        check({tag, "_y"}, bus.y, 0);
        check({tag, "_colour"}, bus.colour, 0);
    endtask

    logic [1:0] exp_g;
    int         err_cnt;
    int         last_x, last_y;
    logic       found;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        bus.frame_start = 1'b0;
        bus.clear_en    = 1'b0;
        set_req(2'b00, 0, 0, 0, 0, 0, 0);

        @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;

        // single request, one-cycle latency, then dropped
        set_req(2'b01, 10, 20, 5, 0, 0, 0);
        @(negedge clock);
        check("t1_grant", bus.grant, 2'b01);
        check("t1_plot", bus.plot, 1);
        check("t1_x", bus.x, 10);
        check("t1_y", bus.y, 20);
        check("t1_colour", bus.colour, 5);
        check("t1_err", bus.range_err, 0);
        bus.req = 2'b00;
        @(negedge clock);
        check("t1_nogrant", bus.grant, 0);
        check("t1_noplot", bus.plot, 0);

        // both held: pointer is 0 now, so requester 1 leads, then alternation
        set_req(2'b11, 1, 2, 1, 3, 4, 2);
        exp_g = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("alt_grant", bus.grant, exp_g);
            check("alt_plot", bus.plot, 1);
            check("alt_x", bus.x, (exp_g == 2'b01) ? 1 : 3);
            check("alt_colour", bus.colour, (exp_g == 2'b01) ? 1 : 2);
            exp_g = ~exp_g;
        end
        bus.req = 2'b00;
        @(negedge clock);
        check("alt_end_grant", bus.grant, 0);

        // single requester held through two grants: idle cycle in between
        set_req(2'b01, 30, 31, 7, 0, 0, 0);
        @(negedge clock);
        check("hold_g1", bus.grant, 2'b01);
        @(negedge clock);
        check("hold_gap_grant", bus.grant, 0);
        check("hold_gap_plot", bus.plot, 0);
        @(negedge clock);
        check("hold_g2", bus.grant, 2'b01);
        check("hold_g2_x", bus.x, 30);
        bus.req = 2'b00;
        @(negedge clock);
        check("hold_end", bus.grant, 0);

        // out-of-range x and y
        set_req(2'b01, 160, 5, 2, 0, 0, 0);
        @(negedge clock);
        check("rx_grant", bus.grant, 2'b01);
        check("rx_plot", bus.plot, 0);
        check("rx_err", bus.range_err, 1);
        bus.req = 2'b00;
        @(negedge clock);
        check("rx_err_clr", bus.range_err, 0);
        set_req(2'b01, 159, 120, 2, 0, 0, 0);
        @(negedge clock);
        check("ry_grant", bus.grant, 2'b01);
        check("ry_plot", bus.plot, 0);
        check("ry_err", bus.range_err, 1);
        bus.req = 2'b00;
        @(negedge clock);
        // boundary pixel (159,119) is in range
        set_req(2'b01, 159, 119, 4, 0, 0, 0);
        @(negedge clock);
        check("edge_plot", bus.plot, 1);
        check("edge_err", bus.range_err, 0);
        bus.req = 2'b00;
        @(negedge clock);

        // frame_start without clear_en does nothing
        bus.frame_start = 1'b1;
        bus.clear_en    = 1'b0;
        @(negedge clock);
        bus.frame_start = 1'b0;
        check("noclr_busy", bus.busy_clear, 0);
        check("noclr_plot", bus.plot, 0);

        // clear pass with both requesters waiting and a second frame_start mid-pass
        set_req(2'b11, 7, 8, 6, 9, 10, 3);
        bus.frame_start = 1'b1;
        bus.clear_en    = 1'b1;
        err_cnt = 0;
        last_x  = -1;
        last_y  = -1;
        for (int i = 0; i < 19200; i++) begin
            @(negedge clock);
            if (i == 0)   bus.frame_start = 1'b0;
            if (i == 100) bus.frame_start = 1'b1;
            if (i == 101) bus.frame_start = 1'b0;
            if (i == 0) begin
                check("clr_first_x", bus.x, 0);
                check("clr_first_y", bus.y, 0);
                check("clr_first_busy", bus.busy_clear, 1);
            end
            if (bus.plot !== 1'b1 || bus.x !== 8'(i % 160) || bus.y !== 7'(i / 160) ||
                bus.colour !== 3'd0 || bus.grant !== 2'b00 || bus.busy_clear !== 1'b1 ||
                bus.clear_done !== 1'b0)
                err_cnt++;
            last_x = int'(bus.x);
            last_y = int'(bus.y);
        end
        check("clr_raster_errs", err_cnt, 0);
        check("clr_last_x", last_x, 159);
        check("clr_last_y", last_y, 119);
        @(negedge clock);
        check("clr_done", bus.clear_done, 1);
        check("clr_done_busy", bus.busy_clear, 0);
        check("clr_done_plot", bus.plot, 0);
        check("clr_done_grant", bus.grant, 0);
        @(negedge clock);
        check("post_clr_grant", bus.grant, 2'b10);
        check("post_clr_plot", bus.plot, 1);
        check("post_clr_x", bus.x, 9);
        check("post_clr_y", bus.y, 10);
        check("post_clr_colour", bus.colour, 3);
        check("post_clr_done", bus.clear_done, 0);
        bus.req = 2'b00;
        @(negedge clock);

        // reset asserted while clearing pixel (40,3)
        bus.frame_start = 1'b1;
        bus.clear_en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clock);
            bus.frame_start = 1'b0;
            if (bus.plot === 1'b1 && bus.x === 8'd40 && bus.y === 7'd3) found = 1'b1;
        end
        check("mid_reach_40_3", found, 1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_plot", bus.plot, 0);
            check("post_rst_busy", bus.busy_clear, 0);
        end
        set_req(2'b11, 7, 8, 6, 9, 10, 3);
        @(negedge clock);
        check("post_rst_grant", bus.grant, 2'b01);
        check("post_rst_x", bus.x, 7);
        bus.req = 2'b00;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
